// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcode encodings, the
// number of legal opcodes and the bit positions inside the response flags.
package alu_pkg;

  localparam logic [3:0] OR   = 4'd0;
  localparam logic [3:0] MUL  = 4'd1;
  localparam logic [3:0] SGE  = 4'd2;
  localparam logic [3:0] MIN  = 4'd3;
  localparam logic [3:0] SRA  = 4'd4;
  localparam logic [3:0] ADD  = 4'd5;
  localparam logic [3:0] SLL  = 4'd6;
  localparam logic [3:0] SLTU = 4'd7;
  localparam logic [3:0] SEQ  = 4'd8;
  localparam logic [3:0] SRL  = 4'd9;
  localparam logic [3:0] NOR  = 4'd10;
  localparam logic [3:0] SLT  = 4'd11;

  // Opcodes 0..NUM_OPS-1 are legal; anything above is reported as an error.
  localparam int NUM_OPS = 12;

  // Bit positions in the 3-bit flags vector {overflow, zero, carry}.
  localparam int CARRY = 0;
  localparam int ZERO  = 1;
  localparam int OVF   = 2;

  typedef logic [2:0] alu_flags_t;

endpackage

// File: rtl/alu_cmd_driver_fifo.sv
// Synchronous FIFO with a registered occupancy count. Used for the command
// queue and for the two-entry response buffer. Storage is cleared on reset so
// the head output reads zero until the first write.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A write at full is only accepted when a read frees the slot this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers (wrap naturally at DEPTH) and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for a combinational ALU. Commands are queued, issued to the ALU
// from registers, and the ALU outputs are captured one cycle later into a
// two-entry response buffer.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low, and ready never depends on valid.
module alu_cmd_driver #(
  parameter int WIDTH     = 64,
  parameter int OPW       = 4,
  parameter int SHW       = 5,
  parameter int TAGW      = 4,
  parameter int CMD_DEPTH = 4,
  parameter int NUM_OPS   = alu_pkg::NUM_OPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shamt,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_err
);

  import alu_pkg::*;

  localparam int CMDW = OPW + 2 * WIDTH + SHW + TAGW;
  localparam int RSPW = WIDTH + 3 + TAGW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]       state_q;
  logic             start;

  logic             cmd_push;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CMDW-1:0]  cmd_wdata;
  logic [CMDW-1:0]  cmd_head;
  logic [OPW-1:0]   hd_opcode;
  logic [WIDTH-1:0] hd_a;
  logic [WIDTH-1:0] hd_b;
  logic [SHW-1:0]   hd_shamt;
  logic [TAGW-1:0]  hd_tag;
  logic             hd_err;

  logic [TAGW-1:0]  tag_q;
  logic             err_q;

  logic             rsp_push;
  logic             rsp_pop;
  logic             rsp_full;
  logic             rsp_empty;
  logic [WIDTH-1:0] cap_result;
  alu_flags_t       cap_flags;
  logic [RSPW-1:0]  rsp_wdata;
  logic [RSPW-1:0]  rsp_head;

  // Ready comes from registered occupancy only; held low while in reset.
  assign cmd_ready = !rst && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag};

  sync_fifo #(.WIDTH(CMDW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_push),
    .wr_data (cmd_wdata),
    .rd_en   (start),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  assign {hd_opcode, hd_a, hd_b, hd_shamt, hd_tag} = cmd_head;
  assign hd_err = (32'(hd_opcode) >= NUM_OPS);

  // Issue only when the response buffer can take the result one cycle later.
  assign start = (state_q == IDLE) && !cmd_empty && !rsp_full;

  // Issue FSM plus the ALU input registers and tag/err pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      tag_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q        <= EXEC;
            alu_opcode     <= hd_opcode;
            alu_input1     <= hd_a;
            alu_input2     <= hd_b;
            alu_shiftValue <= hd_shamt;
            tag_q          <= hd_tag;
            err_q          <= hd_err;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Build the captured response; illegal opcodes report zero result, Z flag.
  always_comb begin
    cap_result = '0;
    cap_flags  = '0;
    if (err_q) begin
      cap_flags[ZERO] = 1'b1;
    end else begin
      cap_result       = alu_result;
      cap_flags[CARRY] = alu_carry;
      cap_flags[ZERO]  = alu_zero;
      cap_flags[OVF]   = alu_overflow;
    end
  end

  assign rsp_push  = (state_q == EXEC);
  assign rsp_wdata = {cap_result, cap_flags, tag_q, err_q};
  assign rsp_pop   = rsp_valid && rsp_ready;

  sync_fifo #(.WIDTH(RSPW), .DEPTH(2)) u_rsp_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rsp_push),
    .wr_data (rsp_wdata),
    .rd_en   (rsp_pop),
    .rd_data (rsp_head),
    .full    (rsp_full),
    .empty   (rsp_empty)
  );

  assign rsp_valid = !rsp_empty;
  assign {rsp_result, rsp_flags, rsp_tag, rsp_err} = rsp_head;

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the combinational 64-bit ALU port set (opcode, input1, input2, shiftValue → result, carryFlag, zeroFlag, overFlowFlag).
- Accepts ALU commands on a valid/ready stream, buffers them, and drives the ALU inputs from registers.
- Captures the ALU outputs one cycle later and returns tagged responses on a valid/ready stream.
- Sits between the team's instruction/test sequencers and any ALU instance with that port set.

Parameters:
- WIDTH, 64: operand/result width.
- OPW, 4: opcode width.
- SHW, 5: shift-amount width.
- TAGW, 4: command tag width.
- CMD_DEPTH, 4: command FIFO entries; power of 2, at least 2.
- NUM_OPS, 12: legal opcodes are 0..NUM_OPS-1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_opcode  in  OPW  ALU opcode.
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_shamt  in  SHW  shift amount.
- cmd_tag  in  TAGW  returned unchanged with the response.
- alu_opcode  out  OPW  registered; to ALU opcode.
- alu_input1  out  WIDTH  registered; to ALU input1.
- alu_input2  out  WIDTH  registered; to ALU input2.
- alu_shiftValue  out  SHW  registered; to ALU shiftValue.
- alu_result  in  WIDTH  from ALU.
- alu_carry  in  1  from ALU.
- alu_zero  in  1  from ALU.
- alu_overflow  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  3  {overflow, zero, carry}.
- rsp_tag  out  TAGW  tag of the command.
- rsp_err  out  1  opcode was illegal (≥ NUM_OPS).

Behaviour:
- Reset: one clock and a synchronous active-high reset; all state is cleared on the clk edge where rst=1.
  - FSM goes to IDLE; FIFO and response buffer are emptied.
  - alu_* outputs = 0; rsp_valid = 0; rsp_result/flags/tag/err = 0; cmd_ready = 0 during reset.
  - cmd_ready = (FIFO not full) from the first cycle after reset.
- Command FIFO:
  - Write when cmd_valid && cmd_ready.
  - Simultaneous push and pop when full is allowed only if the pop frees the slot. cmd_ready is driven from the registered count, so no push occurs at full.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states IDLE and EXEC:
  - IDLE → EXEC when FIFO is not empty and the response buffer has a free slot. On that edge the FIFO pops and the alu_* registers load the head entry; the tag and err bit go to pipeline registers.
  - EXEC → IDLE always, after one cycle. On that edge the response buffer writes {alu_result, alu_overflow, alu_zero, alu_carry, tag, err}.
  - If err=1 the response is written with result=0, flags=3'b010 (zero set), err=1. The illegal opcode is still driven to the ALU but its outputs are ignored.
  - alu_* hold their last value while IDLE; no glitching on the ALU inputs.
  - Throughput is 1 command per 2 cycles.
- Latency: command accepted on edge E → alu_* valid after E+1 → capture at E+2 → rsp_valid high after E+2, i.e. 3 edges with an empty pipeline and rsp_ready=1.
- Response buffer (2 entries, FIFO order):
  - rsp_* present the head entry; rsp_valid = not empty.
  - Pop when rsp_valid && rsp_ready. Push and pop in the same cycle are both honoured.
  - A free slot is checked when entering EXEC, so a capture never overflows the buffer.
- Ordering: responses leave strictly in command order; tags are not interpreted.
- rsp_* are stable while rsp_valid && !rsp_ready.
- Reset mid-operation: any in-flight EXEC capture is discarded, and the FIFO and buffer are flushed. No response is emitted for commands accepted before reset.
- Widths: no arithmetic on data paths. Counters are clog2(CMD_DEPTH)+1 bits for the FIFO and 2 bits for the buffer.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OR=0, MUL=1, SGE=2, MIN=3, SRA=4, ADD=5, SLL=6, SLTU=7, SEQ=8, SRL=9, NOR=10, SLT=11;
  - NUM_OPS;
  - the flag bit positions (CARRY=0, ZERO=1, OVF=2).
- One sub-module, sync_fifo (parameterised width/depth, synchronous active-high reset), instantiated for both the command FIFO and the 2-entry response buffer.

Test Plan:
- ADD a=5, b=7, tag=3, rsp_ready=1 → rsp_valid 3 edges after accept; result=12, flags zero=0, tag=3, err=0; alu_opcode=5 held during EXEC.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 with the ALU model → result=0x8000_0000_0000_0000, overflow bit as returned by the ALU, propagated unchanged into rsp_flags[2].
- OR a=0, b=0 → result=0, rsp_flags[1]=1. Then opcode=13 → err=1, result=0, flags=3'b010.
- rsp_ready=0, push 8 commands back-to-back → exactly 6 accepted (4 FIFO + 2 buffer), cmd_ready low after that. Release rsp_ready → 6 responses in order with tags 0..5; remaining commands accepted afterwards.
- Streaming 10 commands with rsp_ready=1 → one response every 2 cycles, order preserved, alu_* never change outside the IDLE→EXEC edge.
- Assert rst for 1 cycle during EXEC with 3 commands queued → no rsp_valid afterwards, cmd_ready=1 the cycle after reset deasserts, alu_*=0.
